// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-channel TDM link (transmit and receive ends).
// Holds the slot geometry and the receiver framing-state encoding.
package tdm_pkg;

    localparam int TDM_SLOTS  = 8;
    localparam int TDM_SLOT_W = 3;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM receiver: advances on en, clears to 0 (hunt) or 1 (resync).
// wrap flags the last slot of a frame, i.e. the next advance returns to slot 0.
module tdm_slot_cnt
    import tdm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr0,
    input  logic                  clr1,
    output logic [TDM_SLOT_W-1:0] cnt,
    output logic                  wrap
);

    // Clear-to-0 outranks clear-to-1, which outranks a normal advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr0) begin
            cnt <= '0;
        end else if (clr1) begin
            cnt <= TDM_SLOT_W'(1);
        end else if (en) begin
            cnt <= cnt + TDM_SLOT_W'(1);
        end
    end

    assign wrap = (cnt == TDM_SLOT_W'(TDM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux8_rx.sv
// Receive end of the 8-channel TDM link: aligns to the frame strobe, deserialises
// one bit per enabled cycle, and presents all eight channels once per complete frame.
module tdm_demux8_rx
    import tdm_pkg::*;
#(
    parameter bit STRICT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  din,
    input  logic                  frame,
    output logic                  y0,
    output logic                  y1,
    output logic                  y2,
    output logic                  y3,
    output logic                  y4,
    output logic                  y5,
    output logic                  y6,
    output logic                  y7,
    output logic                  valid,
    output logic [TDM_SLOT_W-1:0] slot,
    output logic                  locked,
    output logic                  frame_err
);

    tdm_state_e             state_q, state_d;
    logic [TDM_SLOTS-2:0]   shadow_q, shadow_d;
    logic [TDM_SLOTS-1:0]   y_q;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic                   cap, load, inc, clr0, clr1, wrap;
    logic [TDM_SLOT_W-1:0]  cap_idx;

    tdm_slot_cnt u_slot_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (inc),
        .clr0  (clr0),
        .clr1  (clr1),
        .cnt   (slot),
        .wrap  (wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HUNT;
            shadow_q <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            if (load) begin
                y_q <= {din, shadow_q};
            end
        end
    end

    // Framing decisions for the slot being consumed; nothing moves without en.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        cap_idx = slot;
        inc     = 1'b0;
        clr0    = 1'b0;
        clr1    = 1'b0;
        load    = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (frame) begin
                        cap     = 1'b1;
                        cap_idx = '0;
                        clr1    = 1'b1;
                        state_d = ST_LOCKED;
                    end else begin
                        clr0 = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (slot == '0) begin
                        if (frame || !STRICT) begin
                            cap     = 1'b1;
                            cap_idx = '0;
                            inc     = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            clr0    = 1'b1;
                            state_d = ST_HUNT;
                        end
                    end else if (frame) begin
                        // Early sync: abandon the partial frame and restart at slot 0.
                        err_d   = 1'b1;
                        cap     = 1'b1;
                        cap_idx = '0;
                        clr1    = 1'b1;
                    end else if (wrap) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                        inc     = 1'b1;
                    end else begin
                        cap = 1'b1;
                        inc = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < TDM_SLOTS - 1; i++) begin
            if (cap && cap_idx == TDM_SLOT_W'(i)) begin
                shadow_d[i] = din;
            end
        end
    end

    assign {y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux8_rx.sv
// Self-checking bench for tdm_demux8_rx: a strict and a free-running instance share
// stimulus and are compared with a frame-level reference model of the receiver.
module tb_tdm_demux8_rx;

    logic clk = 1'b0;
    logic rst_n, en, din, frame;

    logic [7:0] y_s, y_l;
    logic       valid_s, valid_l, locked_s, locked_l, err_s, err_l;
    logic [2:0] slot_s, slot_l;
    logic [13:0] obs_s, obs_l;

    int chk  = 0;
    int pass = 0;

    always #5 clk = ~clk;

    tdm_demux8_rx #(.STRICT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .frame(frame),
        .y0(y_s[0]), .y1(y_s[1]), .y2(y_s[2]), .y3(y_s[3]),
        .y4(y_s[4]), .y5(y_s[5]), .y6(y_s[6]), .y7(y_s[7]),
        .valid(valid_s), .slot(slot_s), .locked(locked_s), .frame_err(err_s)
    );

    tdm_demux8_rx #(.STRICT(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .frame(frame),
        .y0(y_l[0]), .y1(y_l[1]), .y2(y_l[2]), .y3(y_l[3]),
        .y4(y_l[4]), .y5(y_l[5]), .y6(y_l[6]), .y7(y_l[7]),
        .valid(valid_l), .slot(slot_l), .locked(locked_l), .frame_err(err_l)
    );

    assign obs_s = {y_s, valid_s, slot_s, locked_s, err_s};
    assign obs_l = {y_l, valid_l, slot_l, locked_l, err_l};

    // Reference model, index 1 = strict receiver, index 0 = free-running receiver.
    int       m_pos[2];
    bit       m_lock[2];
    bit [7:0] m_buf[2];
    bit [7:0] m_y[2];
    bit       m_valid[2];
    bit       m_err[2];

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pos[s] = 0; m_lock[s] = 0; m_buf[s] = '0;
            m_y[s] = '0; m_valid[s] = 0; m_err[s] = 0;
        end
    endfunction

    function automatic void model_step(bit e, bit d, bit f);
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 0;
            m_err[s]   = 0;
            if (!e) continue;
            if (!m_lock[s]) begin
                if (f) begin
                    m_lock[s] = 1; m_buf[s][0] = d; m_pos[s] = 1;
                end
            end else if (f) begin
                m_err[s] = (m_pos[s] != 0);
                m_buf[s][0] = d;
                m_pos[s] = 1;
            end else if (m_pos[s] == 0 && s == 1) begin
                m_err[s]  = 1;
                m_lock[s] = 0;
            end else begin
                m_buf[s][m_pos[s]] = d;
                if (m_pos[s] == 7) begin
                    m_y[s] = m_buf[s];
                    m_valid[s] = 1;
                    m_pos[s] = 0;
                end else begin
                    m_pos[s]++;
                end
            end
        end
    endfunction

    function automatic logic [13:0] exp_vec(int s);
        return {m_y[s], m_valid[s], 3'(m_pos[s]), m_lock[s], m_err[s]};
    endfunction

    task automatic cycle(input bit e, input bit d, input bit f);
        @(negedge clk);
        en = e; din = d; frame = f;
        @(posedge clk);
        model_step(e, d, f);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 0; din = 0; frame = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        en = 0; din = 0; frame = 0; rst_n = 0;
        model_reset();
        #12;
        chk++; if (obs_s !== 14'h0) $display("[TB] FAIL reset_strict: got %h want %h", obs_s, 14'h0); else pass++;
        chk++; if (obs_l !== 14'h0) $display("[TB] FAIL reset_free: got %h want %h", obs_l, 14'h0); else pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_lock();
        bit [7:0] data = 8'b0100_1101;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1, data[i], i == 0);
            chk++; if (obs_s !== exp_vec(1)) $display("[TB] FAIL lock_slot%0d: got %h want %h", i, obs_s, exp_vec(1)); else pass++;
        end
        chk++; if (y_s !== 8'h4D) $display("[TB] FAIL lock_y: got %h want %h", y_s, 8'h4D); else pass++;
        chk++; if ({valid_s, locked_s, slot_s} !== 5'b11_000) $display("[TB] FAIL lock_flags: got %b want %b", {valid_s, locked_s, slot_s}, 5'b11_000); else pass++;
        cycle(0, 0, 0);
        chk++; if (valid_s !== 1'b0) $display("[TB] FAIL lock_valid_drop: got %b want 0", valid_s); else pass++;
    endtask

    task automatic test_gaps();
        bit [7:0] data = 8'b0100_1101;
        int vcyc = -1;
        int n = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1, data[i], i == 0);
            n++;
            if (valid_s === 1'b1) vcyc = n;
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    cycle(0, $urandom_range(0, 1), $urandom_range(0, 1));
                    n++;
                    chk++; if (slot_s !== 3'd4) $display("[TB] FAIL gap_slot_hold: got %0d want 4", slot_s); else pass++;
                end
            end
        end
        chk++; if (vcyc !== 11) $display("[TB] FAIL gap_valid_cycle: got %0d want 11", vcyc); else pass++;
        chk++; if (y_s !== 8'h4D) $display("[TB] FAIL gap_y: got %h want %h", y_s, 8'h4D); else pass++;
    endtask

    task automatic test_early_sync();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 0, i == 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, i == 0);
        cycle(1, 1, 1);
        chk++; if ({err_s, valid_s, slot_s, y_s} !== {1'b1, 1'b0, 3'd1, 8'h00}) $display("[TB] FAIL early_sync: got %b/%b/%0d/%h want 1/0/1/00", err_s, valid_s, slot_s, y_s); else pass++;
        for (int i = 1; i < 8; i++) begin
            cycle(1, 0, 0);
            chk++; if (obs_s !== exp_vec(1)) $display("[TB] FAIL early_resync%0d: got %h want %h", i, obs_s, exp_vec(1)); else pass++;
        end
        chk++; if ({valid_s, y_s} !== {1'b1, 8'h01}) $display("[TB] FAIL early_frame: got %b/%h want 1/01", valid_s, y_s); else pass++;
    endtask

    task automatic test_missing_sync();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 1, i == 0);
        cycle(1, 0, 0);
        chk++; if ({err_s, locked_s, slot_s} !== {1'b1, 1'b0, 3'd0}) $display("[TB] FAIL miss_strict: got %b/%b/%0d want 1/0/0", err_s, locked_s, slot_s); else pass++;
        chk++; if ({err_l, locked_l, slot_l} !== {1'b0, 1'b1, 3'd1}) $display("[TB] FAIL miss_free: got %b/%b/%0d want 0/1/1", err_l, locked_l, slot_l); else pass++;
        for (int i = 1; i < 8; i++) begin
            cycle(1, i[0], 0);
            chk++; if (obs_s !== exp_vec(1)) $display("[TB] FAIL miss_strict_c%0d: got %h want %h", i, obs_s, exp_vec(1)); else pass++;
            chk++; if (obs_l !== exp_vec(0)) $display("[TB] FAIL miss_free_c%0d: got %h want %h", i, obs_l, exp_vec(0)); else pass++;
        end
        chk++; if ({valid_l, y_l} !== {1'b1, 8'hAA}) $display("[TB] FAIL miss_free_frame: got %b/%h want 1/aa", valid_l, y_l); else pass++;
    endtask

    task automatic test_async_reset();
        bit [7:0] data = 8'b1111_1110;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 1, i == 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, i == 0);
        #2;
        rst_n = 0;
        model_reset();
        #1;
        chk++; if (obs_s !== 14'h0) $display("[TB] FAIL areset_strict: got %h want %h", obs_s, 14'h0); else pass++;
        chk++; if (obs_l !== 14'h0) $display("[TB] FAIL areset_free: got %h want %h", obs_l, 14'h0); else pass++;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 8; i++) cycle(1, data[i], i == 0);
        chk++; if ({valid_s, y_s} !== {1'b1, 8'hFE}) $display("[TB] FAIL areset_frame: got %b/%h want 1/fe", valid_s, y_s); else pass++;
    endtask

    task automatic test_back_to_back();
        int vq[$];
        int errs = 0;
        do_reset();
        for (int n = 1; n <= 32; n++) begin
            cycle(1, $urandom_range(0, 1), (n % 8) == 1);
            if (valid_s === 1'b1) vq.push_back(n);
            if (err_s !== 1'b0) errs++;
            chk++; if (obs_s !== exp_vec(1)) $display("[TB] FAIL b2b_c%0d: got %h want %h", n, obs_s, exp_vec(1)); else pass++;
        end
        chk++; if (vq.size() !== 4) $display("[TB] FAIL b2b_count: got %0d want 4", vq.size()); else pass++;
        chk++; if (errs !== 0) $display("[TB] FAIL b2b_errs: got %0d want 0", errs); else pass++;
        for (int i = 1; i < vq.size(); i++) begin
            chk++; if (vq[i] - vq[i-1] !== 8) $display("[TB] FAIL b2b_spacing%0d: got %0d want 8", i, vq[i] - vq[i-1]); else pass++;
        end
    endtask

    task automatic test_random();
        bit e, f;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 9) < 7);
            if (m_lock[1] && m_pos[1] == 0) f = ($urandom_range(0, 9) != 0);
            else f = ($urandom_range(0, 11) == 0);
            cycle(e, $urandom_range(0, 1), f);
            chk++; if (obs_s !== exp_vec(1)) $display("[TB] FAIL rand_strict_c%0d: got %h want %h", n, obs_s, exp_vec(1)); else pass++;
            chk++; if (obs_l !== exp_vec(0)) $display("[TB] FAIL rand_free_c%0d: got %h want %h", n, obs_l, exp_vec(0)); else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
